instr_queue: RTL and testbench

//  Fetch-to-decode instruction FIFO. Buffers fetched 32-bit instructions with

---
 rtl/instr_queue.sv | 123 ++++++++++++
 tb/tb_instr_queue.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/instr_queue.sv
// instr_queue: fetch-to-decode instruction FIFO.
//   Buffers fetched instructions with their PC and fetch-time exception and
//   presents them in order to decode. Emptied by flush_i or rst_i.
//   Optional build macro: INSTR_QUEUE_BYPASS_EN (same-cycle empty bypass).
// Ports:
//   clk_i, rst_i (sync, active-high), flush_i
//   fetch_valid_i/fetch_ready_o, fetch_pc_i, fetch_instr_i,
//   fetch_ex_valid_i, fetch_ex_cause_i        : enqueue side
//   dec_valid_o/dec_ready_i, dec_pc_o, dec_instr_o,
//   dec_ex_valid_o, dec_ex_cause_o            : dequeue side (head entry)
//   count_o                                   : registered occupancy 0..DEPTH
module instr_queue #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             fetch_valid_i,
  output logic             fetch_ready_o,
  input  logic [63:0]      fetch_pc_i,
  input  logic [31:0]      fetch_instr_i,
  input  logic             fetch_ex_valid_i,
  input  logic [63:0]      fetch_ex_cause_i,
  output logic             dec_valid_o,
  input  logic             dec_ready_i,
  output logic [63:0]      dec_pc_o,
  output logic [31:0]      dec_instr_o,
  output logic             dec_ex_valid_o,
  output logic [63:0]      dec_ex_cause_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned IDX_W = CNT_W - 1;

  logic [63:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];
  logic        exv_mem   [DEPTH];
  logic [63:0] cause_mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic full, empty, push, pop, bypass;

  assign full  = (wr_ptr_q[CNT_W-1] != rd_ptr_q[CNT_W-1]) &&
                 (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // Ready is purely registered state, so no combinational path to decode.
  assign fetch_ready_o = !full;

`ifdef INSTR_QUEUE_BYPASS_EN
  // Empty queue with a consumer waiting: hand the fetch entry straight over.
  assign bypass = empty && fetch_valid_i && dec_ready_i && !flush_i;
`else
  assign bypass = 1'b0;
`endif

  assign push = fetch_valid_i && fetch_ready_o && !flush_i && !bypass;
  assign pop  = !empty && dec_ready_i && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = wr_ptr_d - rd_ptr_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; contents are only observable through valid pointers.
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr_q[IDX_W-1:0]]    <= fetch_pc_i;
      instr_mem[wr_ptr_q[IDX_W-1:0]] <= fetch_instr_i;
      exv_mem[wr_ptr_q[IDX_W-1:0]]   <= fetch_ex_valid_i;
      cause_mem[wr_ptr_q[IDX_W-1:0]] <= fetch_ex_cause_i;
    end
  end

  always_comb begin
    dec_valid_o    = 1'b0;
    dec_pc_o       = '0;
    dec_instr_o    = '0;
    dec_ex_valid_o = 1'b0;
    dec_ex_cause_o = '0;
    if (bypass) begin
      dec_valid_o    = 1'b1;
      dec_pc_o       = fetch_pc_i;
      dec_instr_o    = fetch_instr_i;
      dec_ex_valid_o = fetch_ex_valid_i;
      dec_ex_cause_o = fetch_ex_cause_i;
    end else if (!empty && !flush_i) begin
      dec_valid_o    = 1'b1;
      dec_pc_o       = pc_mem[rd_ptr_q[IDX_W-1:0]];
      dec_instr_o    = instr_mem[rd_ptr_q[IDX_W-1:0]];
      dec_ex_valid_o = exv_mem[rd_ptr_q[IDX_W-1:0]];
      dec_ex_cause_o = cause_mem[rd_ptr_q[IDX_W-1:0]];
    end
  end

  assign count_o = count_q;

endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: self-checking bench for instr_queue using a queue-based
// reference model; directed scenarios followed by randomized traffic.
module tb_instr_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        exv;
    logic [63:0] cause;
  } ent_t;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic             flush_i = 1'b0;
  logic             fetch_valid_i = 1'b0;
  logic             fetch_ready_o;
  logic [63:0]      fetch_pc_i = '0;
  logic [31:0]      fetch_instr_i = '0;
  logic             fetch_ex_valid_i = 1'b0;
  logic [63:0]      fetch_ex_cause_i = '0;
  logic             dec_valid_o;
  logic             dec_ready_i = 1'b0;
  logic [63:0]      dec_pc_o;
  logic [31:0]      dec_instr_o;
  logic             dec_ex_valid_o;
  logic [63:0]      dec_ex_cause_o;
  logic [CNT_W-1:0] count_o;

  instr_queue #(.DEPTH(DEPTH)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .flush_i          (flush_i),
    .fetch_valid_i    (fetch_valid_i),
    .fetch_ready_o    (fetch_ready_o),
    .fetch_pc_i       (fetch_pc_i),
    .fetch_instr_i    (fetch_instr_i),
    .fetch_ex_valid_i (fetch_ex_valid_i),
    .fetch_ex_cause_i (fetch_ex_cause_i),
    .dec_valid_o      (dec_valid_o),
    .dec_ready_i      (dec_ready_i),
    .dec_pc_o         (dec_pc_o),
    .dec_instr_o      (dec_instr_o),
    .dec_ex_valid_o   (dec_ex_valid_o),
    .dec_ex_cause_o   (dec_ex_cause_o),
    .count_o          (count_o)
  );

  always #5 clk_i = ~clk_i;

  ent_t model[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t mk(input logic [63:0] pc, input logic [31:0] ins,
                              input logic exv, input logic [63:0] cause);
    ent_t e;
    e.pc = pc; e.instr = ins; e.exv = exv; e.cause = cause;
    return e;
  endfunction

  // One clock cycle: drive, check outputs against the model mid-cycle,
  // then advance the model across the edge. Returns whether fetch was accepted.
  task automatic step(input logic rst, input logic fl, input logic fv,
                      input ent_t e, input logic dr, input logic do_chk,
                      output logic accepted);
    logic byp, exp_valid, popped;
    ent_t exp_e;
    rst_i = rst; flush_i = fl; fetch_valid_i = fv; dec_ready_i = dr;
    fetch_pc_i = e.pc; fetch_instr_i = e.instr;
    fetch_ex_valid_i = e.exv; fetch_ex_cause_i = e.cause;
    #2;
    byp = 1'b0;
`ifdef INSTR_QUEUE_BYPASS_EN
    byp = (model.size() == 0) && fv && dr && !fl;
`endif
    exp_valid = byp || (model.size() > 0 && !fl);
    exp_e = byp ? e : (exp_valid ? model[0] : '0);
    if (do_chk) begin
      chk("dec_valid",   64'(dec_valid_o),    64'(exp_valid));
      chk("fetch_ready", 64'(fetch_ready_o),  64'(model.size() < DEPTH));
      chk("count",       64'(count_o),        64'(model.size()));
      chk("dec_pc",      dec_pc_o,            exp_e.pc);
      chk("dec_instr",   64'(dec_instr_o),    64'(exp_e.instr));
      chk("dec_ex_valid",64'(dec_ex_valid_o), 64'(exp_e.exv));
      chk("dec_ex_cause",dec_ex_cause_o,      exp_e.cause);
    end
    @(posedge clk_i);
    accepted = 1'b0;
    if (rst || fl) begin
      model.delete();
    end else begin
      accepted = fv && (model.size() < DEPTH) && !byp;
      popped   = (model.size() > 0) && dr;
      if (popped)   void'(model.pop_front());
      if (accepted) model.push_back(e);
    end
    #1;
  endtask

  function automatic ent_t rnd_ent();
    return mk({$urandom, $urandom}, $urandom, 1'($urandom_range(0, 1)), {$urandom, $urandom});
  endfunction

  initial begin
    logic acc;
    int   n_acc;
    ent_t idle;
    idle = '0;
    @(posedge clk_i); #1;

    // Reset held two cycles; DUT state unknown beforehand, so no checks yet.
    step(1, 0, 0, idle, 0, 0, acc);
    step(1, 0, 0, idle, 0, 0, acc);
    step(0, 0, 0, idle, 0, 1, acc);

    // Fill to full with decode stalled, offer a 5th, then drain in order.
    for (int i = 0; i < 4; i++) step(0, 0, 1, mk(64'h1000 + 64'(4*i), 32'(i), 0, 0), 0, 1, acc);
    step(0, 0, 1, mk(64'h1010, 32'h55, 0, 0), 0, 1, acc);
    chk("fifth_offer_rejected", 64'(acc), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc_order", dec_pc_o, 64'h1000 + 64'(4*i));
      step(0, 0, 0, idle, 1, 1, acc);
    end
    step(0, 0, 0, idle, 0, 1, acc);

    // Wrap: 10 accepted pushes with decode ready pattern 1,0,1.
    n_acc = 0;
    for (int c = 0; c < 100 && n_acc < 10; c++) begin
      step(0, 0, 1, mk(64'h3000 + 64'(4*n_acc), 32'(n_acc), 0, 0), (c % 3) != 1, 1, acc);
      if (acc) n_acc++;
    end
    chk("wrap_pushes_accepted", 64'(n_acc), 64'd10);
    for (int i = 0; i < 6; i++) step(0, 0, 0, idle, 1, 1, acc);

    // Flush with 3 entries queued and a concurrent offer that must be dropped.
    for (int i = 0; i < 3; i++) step(0, 0, 1, mk(64'h4000 + 64'(4*i), 32'(i), 0, 0), 0, 1, acc);
    step(0, 1, 1, mk(64'hDEAD, 32'hDEAD, 0, 0), 1, 1, acc);
    chk("flush_count", 64'(count_o), 64'd0);
    chk("flush_valid", 64'(dec_valid_o), 64'd0);
    step(0, 0, 0, idle, 1, 1, acc);

    // Exception entry passes through unchanged.
    step(0, 0, 1, mk(64'h5000, 32'h00000013, 1, 64'd1), 0, 1, acc);
    chk("exc_instr", 64'(dec_instr_o), 64'h13);
    chk("exc_valid", 64'(dec_ex_valid_o), 64'd1);
    chk("exc_cause", dec_ex_cause_o, 64'd1);
    step(0, 0, 0, idle, 1, 1, acc);

    // Empty queue, push with decode ready: same-cycle only when bypass is built.
    step(0, 0, 1, mk(64'h2000, 32'h1, 0, 0), 1, 1, acc);
    step(0, 0, 0, idle, 1, 1, acc);

    // Randomized traffic including occasional flush and reset.
    for (int c = 0; c < 400; c++) begin
      step(($urandom % 64) == 0, ($urandom % 32) == 0, ($urandom % 4) != 0,
           rnd_ent(), ($urandom % 3) != 0, 1, acc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
